// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decode-stage control words through the EX, MEM and WB
// pipeline registers. It inserts a bubble on a load-use hazard and squashes
// younger instructions when a BEQ resolves taken in MEM. Saturating
// stall/flush event counters are kept for debug.
//
// Upstream protocol: the decode stage presents a word with id_valid. When
// stall is high the word is not consumed and must be re-presented unchanged
// next cycle. When flush is high the ID word is discarded and IF/ID is cleared.
module ctrl_pipe #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_wen,
   input  logic              id_alusrc,
   input  logic [2:0]        id_aluop,
   input  logic              id_regdst,
   input  logic              id_branch,
   input  logic              id_memwrite,
   input  logic              id_memread,
   input  logic              id_memtoreg,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              mem_zero,
   output logic              ex_alusrc,
   output logic [2:0]        ex_aluop,
   output logic [REG_AW-1:0] ex_dst,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic [REG_AW-1:0] mem_dst,
   output logic              wb_wen,
   output logic              wb_memtoreg,
   output logic [REG_AW-1:0] wb_dst,
   output logic              stall,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // One pipeline-stage record. An all-zero record is a bubble.
   typedef struct packed {
      logic              valid;
      logic              wen;
      logic              alusrc;
      logic [2:0]        aluop;
      logic              branch;
      logic              memwrite;
      logic              memread;
      logic              memtoreg;
      logic [REG_AW-1:0] dst;
   } stage_t;

   stage_t id_word;
   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;

   logic uses_rt;
   logic load_use;
   logic branch_taken;

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Build the incoming stage record, resolving the destination register;
   // an invalid ID slot becomes a bubble.
   always_comb begin
      id_word = '0;
      if (id_valid) begin
         id_word.valid    = 1'b1;
         id_word.wen      = id_wen;
         id_word.alusrc   = id_alusrc;
         id_word.aluop    = id_aluop;
         id_word.branch   = id_branch;
         id_word.memwrite = id_memwrite;
         id_word.memread  = id_memread;
         id_word.memtoreg = id_memtoreg;
         id_word.dst      = id_regdst ? id_rd : id_rt;
      end
   end

   // Hazard and branch detection. rt counts as a source only for R-type and
   // branch operands (alusrc=0) and for store data. Loads into r0 never
   // hazard. A taken branch overrides the stall because the stalled
   // instruction is being squashed anyway.
   always_comb begin
      uses_rt      = ~id_alusrc | id_memwrite;
      load_use     = ex_q.valid & ex_q.memread & ex_q.wen &
                     (ex_q.dst != '0) & id_valid &
                     ((ex_q.dst == id_rs) | ((ex_q.dst == id_rt) & uses_rt));
      branch_taken = mem_q.valid & mem_q.branch & mem_zero;
      stall        = load_use & ~branch_taken;
      flush        = branch_taken;
   end

   // Stage registers: a flush bubbles EX and MEM, a stall bubbles EX only,
   // and WB always takes whatever leaves MEM.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= branch_taken ? '0 : ex_q;
         ex_q  <= (branch_taken | load_use) ? '0 : id_word;
      end
   end

   // Saturating debug counters; each one holds at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Stage outputs; memory strobes and register write are qualified by valid.
   assign ex_alusrc    = ex_q.alusrc;
   assign ex_aluop     = ex_q.aluop;
   assign ex_dst       = ex_q.dst;
   assign mem_memread  = mem_q.valid & mem_q.memread;
   assign mem_memwrite = mem_q.valid & mem_q.memwrite;
   assign mem_dst      = mem_q.dst;
   assign wb_wen       = wb_q.valid & wb_q.wen;
   assign wb_memtoreg  = wb_q.memtoreg;
   assign wb_dst       = wb_q.dst;
   assign stall_cnt    = stall_cnt_q;
   assign flush_cnt    = flush_cnt_q;

   // WB keeps the full record for debug visibility; these fields drive nothing.
   logic unused_wb_fields;
   assign unused_wb_fields = ^{wb_q.alusrc, wb_q.aluop, wb_q.branch,
                               wb_q.memwrite, wb_q.memread};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed, table-driven bench for ctrl_pipe. The main instance
// uses default widths. A second instance with CNT_W=2 shares the same inputs
// and is used for counter saturation.
module tb_ctrl_pipe;

   typedef struct packed {
      logic       valid;
      logic       wen;
      logic       alusrc;
      logic [2:0] aluop;
      logic       regdst;
      logic       branch;
      logic       memwrite;
      logic       memread;
      logic       memtoreg;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } ctrl_t;

   typedef struct packed {
      logic       ex_alusrc;
      logic [2:0] ex_aluop;
      logic [4:0] ex_dst;
      logic       mem_memread;
      logic       mem_memwrite;
      logic [4:0] mem_dst;
      logic       wb_wen;
      logic       wb_memtoreg;
      logic [4:0] wb_dst;
      logic       stall;
      logic       flush;
      logic [15:0] stall_cnt;
      logic [15:0] flush_cnt;
   } exp_t;

   typedef struct {
      ctrl_t id;
      logic  mz;
      exp_t  e;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   ctrl_t      id_c;
   logic       mem_zero;
   logic       ex_alusrc, mem_memread, mem_memwrite, wb_wen, wb_memtoreg, stall, flush;
   logic [2:0] ex_aluop;
   logic [4:0] ex_dst, mem_dst, wb_dst;
   logic [15:0] stall_cnt, flush_cnt;

   logic       s_ex_alusrc, s_mem_memread, s_mem_memwrite, s_wb_wen, s_wb_memtoreg, s_stall, s_flush;
   logic [2:0] s_ex_aluop;
   logic [4:0] s_ex_dst, s_mem_dst, s_wb_dst;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   ctrl_pipe #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_c.valid), .id_wen(id_c.wen), .id_alusrc(id_c.alusrc),
      .id_aluop(id_c.aluop), .id_regdst(id_c.regdst), .id_branch(id_c.branch),
      .id_memwrite(id_c.memwrite), .id_memread(id_c.memread),
      .id_memtoreg(id_c.memtoreg), .id_rs(id_c.rs), .id_rt(id_c.rt),
      .id_rd(id_c.rd), .mem_zero(mem_zero),
      .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_dst(ex_dst),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_dst(mem_dst),
      .wb_wen(wb_wen), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
      .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   ctrl_pipe #(.REG_AW(5), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst),
      .id_valid(id_c.valid), .id_wen(id_c.wen), .id_alusrc(id_c.alusrc),
      .id_aluop(id_c.aluop), .id_regdst(id_c.regdst), .id_branch(id_c.branch),
      .id_memwrite(id_c.memwrite), .id_memread(id_c.memread),
      .id_memtoreg(id_c.memtoreg), .id_rs(id_c.rs), .id_rt(id_c.rt),
      .id_rd(id_c.rd), .mem_zero(mem_zero),
      .ex_alusrc(s_ex_alusrc), .ex_aluop(s_ex_aluop), .ex_dst(s_ex_dst),
      .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite), .mem_dst(s_mem_dst),
      .wb_wen(s_wb_wen), .wb_memtoreg(s_wb_memtoreg), .wb_dst(s_wb_dst),
      .stall(s_stall), .flush(s_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   vec_t vq[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s step %0d got %0h want %0h", name, idx, act, want);
      end
   endtask

   function automatic ctrl_t mkc(input int v, input int wen, input int alusrc,
                                 input int aluop, input int regdst, input int br,
                                 input int mw, input int mr, input int mtr,
                                 input int rs, input int rt, input int rd);
      ctrl_t c;
      c.valid = 1'(v);      c.wen = 1'(wen);       c.alusrc = 1'(alusrc);
      c.aluop = 3'(aluop);  c.regdst = 1'(regdst); c.branch = 1'(br);
      c.memwrite = 1'(mw);  c.memread = 1'(mr);    c.memtoreg = 1'(mtr);
      c.rs = 5'(rs);        c.rt = 5'(rt);         c.rd = 5'(rd);
      return c;
   endfunction

   function automatic exp_t mke(input int ea, input int eop, input int ed,
                                input int mr, input int mw, input int md,
                                input int ww, input int wm, input int wd,
                                input int st, input int fl, input int sc, input int fc);
      exp_t e;
      e.ex_alusrc = 1'(ea);   e.ex_aluop = 3'(eop);    e.ex_dst = 5'(ed);
      e.mem_memread = 1'(mr); e.mem_memwrite = 1'(mw); e.mem_dst = 5'(md);
      e.wb_wen = 1'(ww);      e.wb_memtoreg = 1'(wm);  e.wb_dst = 5'(wd);
      e.stall = 1'(st);       e.flush = 1'(fl);
      e.stall_cnt = 16'(sc);  e.flush_cnt = 16'(fc);
      return e;
   endfunction

   task automatic add(input ctrl_t c, input logic mz, input exp_t e);
      vec_t v;
      v.id = c; v.mz = mz; v.e = e;
      vq.push_back(v);
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge.
   task automatic drive(input ctrl_t c, input logic mz);
      id_c     = c;
      mem_zero = mz;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   ctrl_t NOP, ADD3, LW2, ADD2, ADDI2, LW0, ADD0, SW2, SW34, BEQ;

   initial begin
      //           v wen src op rd br mw mr mtr rs rt rd
      NOP   = '0;
      ADD3  = mkc(1, 1, 0, 2, 1, 0, 0, 0, 1, 1, 2, 3);
      LW2   = mkc(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 2, 0);
      ADD2  = mkc(1, 1, 0, 2, 1, 0, 0, 0, 1, 2, 4, 5);
      ADDI2 = mkc(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0);
      LW0   = mkc(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      ADD0  = mkc(1, 1, 0, 2, 1, 0, 0, 0, 1, 0, 4, 5);
      SW2   = mkc(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 0);
      SW34  = mkc(1, 0, 1, 0, 0, 0, 1, 0, 0, 3, 4, 0);
      BEQ   = mkc(1, 0, 0, 6, 0, 1, 0, 0, 0, 1, 2, 0);

      // Expected columns: ex(src op dst) mem(rd wr dst) wb(wen mtr dst) stall flush scnt fcnt
      // ADD r3 then NOPs
      add(ADD3,  0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0));
      add(NOP,   0, mke(0,2,3, 0,0,0, 0,0,0, 0,0, 0,0));
      add(NOP,   0, mke(0,0,0, 0,0,3, 0,0,0, 0,0, 0,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 1,1,3, 0,0, 0,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0));
      // LW r2 then ADD rs=2: one stall, bubble travels down
      add(LW2,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0));
      add(ADD2,  0, mke(1,0,2, 0,0,0, 0,0,0, 1,0, 0,0));
      add(ADD2,  0, mke(0,0,0, 1,0,2, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,2,5, 0,0,0, 1,0,2, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,5, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 1,1,5, 0,0, 1,0));
      // LW r2 then ADDI rt=2: no stall
      add(LW2,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 1,0));
      add(ADDI2, 0, mke(1,0,2, 0,0,0, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(1,0,2, 1,0,2, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,2, 1,0,2, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 1,1,2, 0,0, 1,0));
      // LW r0 then ADD rs=0: no stall
      add(LW0,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 1,0));
      add(ADD0,  0, mke(1,0,0, 0,0,0, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,2,5, 1,0,0, 0,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,5, 1,0,0, 0,0, 1,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 1,1,5, 0,0, 1,0));
      // LW r2 then SW rt=2: stall
      add(LW2,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 1,0));
      add(SW2,   0, mke(1,0,2, 0,0,0, 0,0,0, 1,0, 1,0));
      add(SW2,   0, mke(0,0,0, 1,0,2, 0,0,0, 0,0, 2,0));
      add(NOP,   0, mke(1,0,2, 0,0,0, 1,0,2, 0,0, 2,0));
      add(NOP,   0, mke(0,0,0, 0,1,2, 0,0,0, 0,0, 2,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,2, 0,0, 2,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,0));
      // BEQ taken in MEM: SW and ADD behind it squashed
      add(BEQ,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,0));
      add(SW34,  0, mke(0,6,2, 0,0,0, 0,0,0, 0,0, 2,0));
      add(ADD3,  1, mke(1,0,4, 0,0,2, 0,0,0, 0,1, 2,0));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,2, 0,0, 2,1));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,1));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,1));
      // BEQ not taken: SW proceeds
      add(BEQ,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,1));
      add(SW34,  0, mke(0,6,2, 0,0,0, 0,0,0, 0,0, 2,1));
      add(NOP,   0, mke(1,0,4, 0,0,2, 0,0,0, 0,0, 2,1));
      add(NOP,   0, mke(0,0,0, 0,1,4, 0,0,2, 0,0, 2,1));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,4, 0,0, 2,1));
      // Taken branch coincides with load-use hazard: flush wins
      add(BEQ,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,1));
      add(LW2,   0, mke(0,6,2, 0,0,0, 0,0,0, 0,0, 2,1));
      add(ADD2,  1, mke(1,0,2, 0,0,2, 0,0,0, 0,1, 2,1));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,2, 0,0, 2,2));
      add(NOP,   0, mke(0,0,0, 0,0,0, 0,0,0, 0,0, 2,2));

      // reset sequence
      drive(NOP, 1'b0);
      rst = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;

      // table-driven vectors
      foreach (vq[i]) begin
         drive(vq[i].id, vq[i].mz);
         @(negedge clk);
         chk("ex_alusrc",    i, 32'(ex_alusrc),    32'(vq[i].e.ex_alusrc));
         chk("ex_aluop",     i, 32'(ex_aluop),     32'(vq[i].e.ex_aluop));
         chk("ex_dst",       i, 32'(ex_dst),       32'(vq[i].e.ex_dst));
         chk("mem_memread",  i, 32'(mem_memread),  32'(vq[i].e.mem_memread));
         chk("mem_memwrite", i, 32'(mem_memwrite), 32'(vq[i].e.mem_memwrite));
         chk("mem_dst",      i, 32'(mem_dst),      32'(vq[i].e.mem_dst));
         chk("wb_wen",       i, 32'(wb_wen),       32'(vq[i].e.wb_wen));
         chk("wb_memtoreg",  i, 32'(wb_memtoreg),  32'(vq[i].e.wb_memtoreg));
         chk("wb_dst",       i, 32'(wb_dst),       32'(vq[i].e.wb_dst));
         chk("stall",        i, 32'(stall),        32'(vq[i].e.stall));
         chk("flush",        i, 32'(flush),        32'(vq[i].e.flush));
         chk("stall_cnt",    i, 32'(stall_cnt),    32'(vq[i].e.stall_cnt));
         chk("flush_cnt",    i, 32'(flush_cnt),    32'(vq[i].e.flush_cnt));
         next_cycle();
      end

      // Mid-stream reset: a load sits in EX with a consumer in ID when rst hits.
      drive(LW2, 1'b0);
      next_cycle();
      drive(ADD2, 1'b0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_stall",     1000, 32'(stall),     32'd0);
      chk("rst_flush",     1000, 32'(flush),     32'd0);
      chk("rst_ex",        1000, 32'({ex_alusrc, ex_aluop, ex_dst}), 32'd0);
      chk("rst_mem",       1000, 32'({mem_memread, mem_memwrite, mem_dst}), 32'd0);
      chk("rst_wb",        1000, 32'({wb_wen, wb_memtoreg, wb_dst}), 32'd0);
      chk("rst_stall_cnt", 1000, 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 1000, 32'(flush_cnt), 32'd0);
      next_cycle();

      // Five load-use stalls; the 2-bit counter must stop at 3.
      for (int k = 0; k < 5; k++) begin
         drive(LW2, 1'b0);
         next_cycle();
         drive(ADD2, 1'b0);
         @(negedge clk);
         chk("sat_stall_pulse", 2000 + k, 32'(stall), 32'd1);
         next_cycle();
         drive(ADD2, 1'b0);
         next_cycle();
      end
      drive(NOP, 1'b0);
      @(negedge clk);
      chk("sat_stall_cnt_16", 3000, 32'(stall_cnt),   32'd5);
      chk("sat_stall_cnt_2",  3000, 32'(s_stall_cnt), 32'd3);
      chk("sat_flush_cnt_2",  3000, 32'(s_flush_cnt), 32'd0);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the per-instruction control word produced by the decode-stage control unit and carries it through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and issues a one-cycle stall with a bubble.
- Squashes younger instructions on a taken branch resolved in MEM.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_wen  in  1  register write enable from control unit
- id_alusrc  in  1  ALU operand B: 1 = immediate
- id_aluop  in  3  ALU operation
- id_regdst  in  1  destination select: 1 = rd, 0 = rt
- id_branch  in  1  BEQ
- id_memwrite  in  1  store
- id_memread  in  1  load
- id_memtoreg  in  1  WB source: 1 = ALU, 0 = memory
- id_rs  in  REG_AW  source register A
- id_rt  in  REG_AW  source register B / store data / load destination
- id_rd  in  REG_AW  R-type destination
- mem_zero  in  1  ALU zero flag of the instruction now in MEM
- ex_alusrc  out  1  EX-stage operand select
- ex_aluop  out  3  EX-stage ALU operation
- ex_dst  out  REG_AW  EX-stage resolved destination
- mem_memread  out  1  MEM-stage load strobe, gated by valid
- mem_memwrite  out  1  MEM-stage store strobe, gated by valid
- mem_dst  out  REG_AW  MEM-stage destination
- wb_wen  out  1  register-file write enable, gated by valid
- wb_memtoreg  out  1  WB source select
- wb_dst  out  REG_AW  register-file write address
- stall  out  1  hold PC and IF/ID register this cycle (combinational)
- flush  out  1  clear IF/ID register this cycle (combinational)
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset: all stage registers cleared, including valid bits and every control field. All outputs read 0. Counters are 0.
- Stage registers: EX, MEM and WB each hold valid, wen, alusrc, aluop, branch, memwrite, memread, memtoreg and dst.
- Destination resolve at ID→EX load: dst = id_regdst ? id_rd : id_rt.
- Latency: an ID control word appears on the EX outputs 1 cycle later, on MEM outputs after 2 cycles, on WB outputs after 3 cycles.
- Bubble: valid=0 and all fields 0, so no write, no memory access and no branch.
- Load-use hazard, combinational. All of the following must hold:
  - ex_valid & ex_memread & ex_wen & (ex_dst != 0) & id_valid;
  - and either ex_dst == id_rs, or (ex_dst == id_rt & uses_rt), where uses_rt = ~id_alusrc | id_memwrite.
- On hazard: stall=1 and EX loads a bubble. MEM and WB advance normally. The ID instruction is re-presented next cycle by the upstream hold.
- Branch taken, combinational: mem_valid & mem_branch & mem_zero.
- On taken branch:
  - flush=1;
  - EX and MEM load bubbles, squashing the ID and EX instructions;
  - WB takes the BEQ (wen=0, harmless).
- Priority: taken branch wins over a load-use hazard in the same cycle. In that case stall=0 and only flush_cnt increments.
- Otherwise every stage advances each cycle. Invalid ID input loads a bubble.
- Gating: mem_memread, mem_memwrite and wb_wen are ANDed with their stage valid.
- r0: writes to dst 0 still propagate, since the register file ignores them; r0 never triggers a hazard.
- Counters: +1 per stall cycle or flush cycle, and hold at all-ones (no wrap).
- Reset asserted mid-stream: all in-flight instructions are discarded on that edge. No stall or flush is asserted in the cycle after reset.

Test Plan:
- Reset: run traffic, assert rst for 1 cycle mid-stream → next cycle all outputs 0 and counters 0; a load in EX does not cause a stall after reset.
- ADD r3,r1,r2 (regdst=1, rd=3), then NOPs → ex_dst=3 at T+1; wb_wen=1, wb_dst=3, wb_memtoreg=1 at T+3; stall=0, flush=0 throughout.
- LW r2 at T, ADD rs=2 at T+1 → stall=1 for exactly 1 cycle. A bubble appears in EX at T+2 and in WB at T+4 with wb_wen=0. The ADD reaches WB at T+5. stall_cnt=1.
- LW r2 then ADDI rt=2 (alusrc=1) → no stall. LW r0 then ADD rs=0 → no stall. LW r2 then SW rt=2 → stall.
- BEQ with mem_zero=1 in MEM → flush=1 for 1 cycle. The two younger instructions never assert mem_memwrite or wb_wen. flush_cnt=1. With mem_zero=0 → no flush.
- Branch taken in MEM while a load-use hazard is present in the same cycle → flush=1, stall=0, flush_cnt+1, stall_cnt unchanged. With CNT_W=2, 5 stall cycles → stall_cnt saturates at 3.
